// File: rtl/cgra_fu_pkg.sv
// ---------------------------------------------------------------------------
// cgra_fu_pkg
// Shared definitions for the CGRA tile functional units.
//   - Adder mode encodings carried in the low bits of the operation word.
//   - Field positions inside the 16-bit config_in operation word.
//   - Small helper functions for decoding the operation word.
// ---------------------------------------------------------------------------
package cgra_fu_pkg;

    // Adder mode encodings (config_in[1:0])
    localparam logic [1:0] ADD_4X16 = 2'd0;  // four independent 16-bit adds
    localparam logic [1:0] ADD_2X32 = 2'd1;  // two 32-bit adds
    localparam logic [1:0] ADD_1X64 = 2'd3;  // one 64-bit add

    // Operation word layout
    localparam int CONFIG_W      = 16;
    localparam int ADDER_CFG_LSB = 0;
    localparam int ADDER_CFG_W   = 2;
    localparam int DEST_LSB      = 2;
    localparam int DEST_W        = 4;

    // True for the three encodings that describe a real operation.
    function automatic logic adder_mode_valid(input logic [ADDER_CFG_W-1:0] mode);
        logic ok;
        case (mode)
            ADD_4X16: ok = 1'b1;
            ADD_2X32: ok = 1'b1;
            ADD_1X64: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Whether the carry out of lane (lane_idx-1) feeds lane lane_idx.
    // Lane 0 never receives a carry; a 2x32 add pairs lanes {1,0}, {3,2}, ...
    function automatic logic adder_link_en(input logic [ADDER_CFG_W-1:0] mode,
                                           input int                     lane_idx);
        logic en;
        if (lane_idx == 0) begin
            en = 1'b0;
        end else begin
            case (mode)
                ADD_4X16: en = 1'b0;
                ADD_2X32: en = ((lane_idx % 2) == 1);
                ADD_1X64: en = 1'b1;
                default:  en = 1'b0;
            endcase
        end
        return en;
    endfunction

endpackage : cgra_fu_pkg

// File: rtl/adder_lane.sv
// ---------------------------------------------------------------------------
// adder_lane
// One width-bit lane of the SIMD adder: sum = a + b + cin, with carry out.
// Purely combinational; the parent decides whether cin is connected to the
// neighbouring lane's carry or tied off.
//
// Ports
//   i_a, i_b : lane operands
//   i_cin    : carry into the lane
//   o_sum    : lane sum, modulo 2^width
//   o_cout   : carry out of the lane
// ---------------------------------------------------------------------------
module adder_lane #(
    parameter int width = 16
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    input  logic             i_cin,
    output logic [width-1:0] o_sum,
    output logic             o_cout
);

    logic [width:0] w_full;

    // Widen by one bit so the carry out falls into the MSB.
    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{width{1'b0}}, i_cin};
    assign o_sum  = w_full[width-1:0];
    assign o_cout = w_full[width];

endmodule : adder_lane

// File: rtl/cgra_adder_fu.sv
// ---------------------------------------------------------------------------
// cgra_adder_fu
// Configurable SIMD adder for the CGRA tile datapath. Two operands of
// num_inputs lanes each are added as 4x16, 2x32 or 1x64 depending on the
// operation word. Results, the routing tag and a valid strobe are registered
// (one cycle latency).
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   inputs    : operand lanes; A lane i = inputs[i], B lane i = inputs[i+num_inputs]
//   on_off    : issue enable, one operation per edge while high
//   config_in : [1:0] adder mode, [5:2] dest_info, [15:6] reserved
//   outputs   : registered result lanes, lane 0 least significant
//   dest_info : registered routing tag of the result on outputs
//   ack       : registered result-valid level
// ---------------------------------------------------------------------------
module cgra_adder_fu
    import cgra_fu_pkg::*;
#(
    parameter int width      = 16,
    parameter int num_inputs = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     inputs    [2*num_inputs],
    input  logic                 on_off,
    input  logic [CONFIG_W-1:0]  config_in,
    output logic [width-1:0]     outputs   [num_inputs],
    output logic [DEST_W-1:0]    dest_info,
    output logic                 ack
);

    // ---------------------------------------------------------------------
    // Operation word decode
    // ---------------------------------------------------------------------
    logic [ADDER_CFG_W-1:0] w_mode;
    logic [DEST_W-1:0]      w_dest;
    logic                   w_mode_ok;
    logic [num_inputs-1:0]  w_link_en;
    logic [width-1:0]       w_sum [num_inputs];

    assign w_mode    = config_in[ADDER_CFG_LSB +: ADDER_CFG_W];
    assign w_dest    = config_in[DEST_LSB +: DEST_W];
    assign w_mode_ok = adder_mode_valid(w_mode);

    // Per-boundary carry enable, derived only from the current mode so a
    // result never mixes two modes.
    always_comb begin
        w_link_en = '0;
        for (int i = 0; i < num_inputs; i++) begin
            w_link_en[i] = adder_link_en(w_mode, i);
        end
    end

    // ---------------------------------------------------------------------
    // Lane adders. Each generate block owns its carry out so the ripple
    // between lanes is a chain of distinct nets rather than one vector.
    // ---------------------------------------------------------------------
    for (genvar g = 0; g < num_inputs; g++) begin : g_lane
        logic w_cin;
        logic w_cout;

        if (g == 0) begin : g_first
            assign w_cin = 1'b0;
        end else begin : g_rest
            assign w_cin = w_link_en[g] & g_lane[g-1].w_cout;
        end

        adder_lane #(
            .width (width)
        ) u_lane (
            .i_a    (inputs[g]),
            .i_b    (inputs[g+num_inputs]),
            .i_cin  (w_cin),
            .o_sum  (w_sum[g]),
            .o_cout (w_cout)
        );
    end

    // Reserved config bits, the always-zero lane-0 link and the carry out of
    // the top lane have no destination.
    logic w_unused_bits;
    assign w_unused_bits = ^{config_in[CONFIG_W-1:DEST_LSB+DEST_W],
                             w_link_en[0],
                             g_lane[num_inputs-1].w_cout};

    // ---------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------
    logic [width-1:0]  r_outputs [num_inputs];
    logic [DEST_W-1:0] r_dest;
    logic              r_ack;

    // Result, tag and valid capture: valid issue loads, invalid issue clears,
    // idle holds data and drops ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < num_inputs; i++) begin
                r_outputs[i] <= {width{1'b0}};
            end
            r_dest <= {DEST_W{1'b0}};
            r_ack  <= 1'b0;
        end else if (on_off) begin
            if (w_mode_ok) begin
                for (int i = 0; i < num_inputs; i++) begin
                    r_outputs[i] <= w_sum[i];
                end
                r_dest <= w_dest;
                r_ack  <= 1'b1;
            end else begin
                for (int i = 0; i < num_inputs; i++) begin
                    r_outputs[i] <= {width{1'b0}};
                end
                r_dest <= {DEST_W{1'b0}};
                r_ack  <= 1'b0;
            end
        end else begin
            r_ack <= 1'b0;
        end
    end

    assign outputs   = r_outputs;
    assign dest_info = r_dest;
    assign ack       = r_ack;

endmodule : cgra_adder_fu

// File: tb/tb_cgra_adder_fu.sv
module tb_cgra_adder_fu;
    import cgra_fu_pkg::*;

    typedef logic [3:0][15:0] lane4_t;   // index 0 = lane 0

    typedef struct packed {
        lane4_t     o;
        logic [3:0] d;
        logic       a;
    } exp_t;

    typedef struct packed {
        lane4_t      a;
        lane4_t      b;
        logic [15:0] cfg;
        logic        on;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [15:0] inputs  [8];
    logic        on_off;
    logic [15:0] config_in;
    logic [15:0] outputs [4];
    logic [3:0]  dest_info;
    logic        ack;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb [$];
    exp_t last;

    cgra_adder_fu #(.width(16), .num_inputs(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .inputs    (inputs),
        .on_off    (on_off),
        .config_in (config_in),
        .outputs   (outputs),
        .dest_info (dest_info),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input exp_t e);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s lane%0d", nm, i), {48'd0, outputs[i]}, {48'd0, e.o[i]});
        end
        chk({nm, " dest"}, {60'd0, dest_info}, {60'd0, e.d});
        chk({nm, " ack"},  {63'd0, ack},       {63'd0, e.a});
    endtask

    // Independent reference: whole-segment arithmetic on 16/32/64-bit slices.
    function automatic exp_t model(input lane4_t a, input lane4_t b,
                                   input logic [15:0] cfg, input logic on,
                                   input exp_t prev);
        exp_t        r;
        logic [63:0] av, bv, s;
        av = a;
        bv = b;
        s  = 64'd0;
        r  = prev;
        r.a = 1'b0;
        if (on) begin
            case (cfg[1:0])
                2'd0: for (int i = 0; i < 4; i++) s[16*i +: 16] = av[16*i +: 16] + bv[16*i +: 16];
                2'd1: begin
                    s[31:0]  = av[31:0]  + bv[31:0];
                    s[63:32] = av[63:32] + bv[63:32];
                end
                2'd3: s = av + bv;
                default: s = 64'd0;
            endcase
            r.o = s;
            r.d = (cfg[1:0] == 2'd2) ? 4'd0 : cfg[5:2];
            r.a = (cfg[1:0] != 2'd2);
        end
        return r;
    endfunction

    task automatic drive(input lane4_t a, input lane4_t b, input logic [15:0] cfg, input logic on);
        for (int i = 0; i < 4; i++) begin
            inputs[i]   = a[i];
            inputs[i+4] = b[i];
        end
        config_in = cfg;
        on_off    = on;
    endtask

    // Drive one operation, push its expectation, then compare after the edge.
    task automatic apply(input string nm, input lane4_t a, input lane4_t b,
                         input logic [15:0] cfg, input logic on, input exp_t e);
        exp_t got;
        drive(a, b, cfg, on);
        sb.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries expected 1", nm);
        end else begin
            got = sb.pop_front();
            chk_all(nm, got);
        end
    endtask

    vec_t   vecs [12];
    lane4_t a0, b0, aff, b1, ac, bc;
    exp_t   zero_e;

    initial begin
        a0  = {16'd30000, 16'd20000, 16'd10000, 16'd0};
        b0  = {16'd4464,  16'd60000, 16'd50000, 16'd40000};
        aff = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        b1  = {16'd0, 16'd0, 16'd0, 16'd1};
        ac  = {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        bc  = {16'h0000, 16'h0000, 16'h0001, 16'h0000};
        zero_e = '0;

        vecs[0]  = '{a0,  b0,  16'h0000, 1'b1, '{{16'd34464, 16'd14464, 16'd60000, 16'd40000}, 4'd0,  1'b1}};
        vecs[1]  = '{a0,  b0,  16'h0001, 1'b1, '{{16'd34465, 16'd14464, 16'd60000, 16'd40000}, 4'd0,  1'b1}};
        vecs[2]  = '{a0,  b0,  16'h0003, 1'b1, '{{16'd34465, 16'd14464, 16'd60000, 16'd40000}, 4'd0,  1'b1}};
        vecs[3]  = '{aff, b1,  16'h0000, 1'b1, '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000},     4'd0,  1'b1}};
        vecs[4]  = '{aff, b1,  16'h0001, 1'b1, '{{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},     4'd0,  1'b1}};
        vecs[5]  = '{aff, b1,  16'h0003, 1'b1, '{{16'h0000, 16'h0000, 16'h0000, 16'h0000},     4'd0,  1'b1}};
        vecs[6]  = '{a0,  b0,  16'h0002, 1'b1, '{64'd0, 4'd0, 1'b0}};
        vecs[7]  = '{a0,  b0,  16'h0034, 1'b1, '{{16'd34464, 16'd14464, 16'd60000, 16'd40000}, 4'd13, 1'b1}};
        vecs[8]  = '{a0,  b0,  16'h0036, 1'b1, '{64'd0, 4'd0, 1'b0}};
        vecs[9]  = '{ac,  bc,  16'h0003, 1'b1, '{{16'h0001, 16'h0000, 16'h0000, 16'h0000},     4'd0,  1'b1}};
        vecs[10] = '{ac,  bc,  16'hFFC5, 1'b1, '{{16'h0000, 16'hFFFF, 16'h0000, 16'h0000},     4'd1,  1'b1}};
        vecs[11] = '{aff, aff, 16'h0000, 1'b0, '{{16'h0000, 16'hFFFF, 16'h0000, 16'h0000},     4'd1,  1'b0}};

        // Reset state, asserted from time zero
        reset = 1'b0;
        drive('0, '0, 16'h0000, 1'b0);
        #12;
        chk_all("reset", zero_e);
        @(negedge clk);
        reset = 1'b1;
        apply("idle_after_reset", '0, '0, 16'h0000, 1'b0, zero_e);

        // Table-driven vectors (back-to-back issues, ack stays high)
        for (int k = 0; k < 12; k++) begin
            apply($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].cfg, vecs[k].on, vecs[k].e);
        end

        // Random operations against the segment-arithmetic model
        for (int k = 0; k < 24; k++) begin
            lane4_t      ra, rb;
            logic [15:0] rc;
            logic        ron;
            for (int i = 0; i < 4; i++) begin
                ra[i] = 16'($urandom);
                rb[i] = 16'($urandom);
            end
            rc  = 16'($urandom);
            ron = ($urandom_range(0, 3) != 0);
            apply($sformatf("rnd%0d", k), ra, rb, rc, ron, model(ra, rb, rc, ron, last));
        end

        // Valid op then drop on_off: data holds, ack falls
        apply("pre_hold", a0, b0, 16'h0008, 1'b1,
              '{{16'd34464, 16'd14464, 16'd60000, 16'd40000}, 4'd2, 1'b1});
        apply("hold", aff, aff, 16'h0003, 1'b0,
              '{{16'd34464, 16'd14464, 16'd60000, 16'd40000}, 4'd2, 1'b0});

        // Mid-stream asynchronous reset clears without a clock edge
        apply("pre_reset", a0, b0, 16'h003C, 1'b1,
              '{{16'd34464, 16'd14464, 16'd60000, 16'd40000}, 4'd15, 1'b1});
        drive(aff, b1, 16'h0007, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", zero_e);
        @(posedge clk);
        #1;
        chk_all("reset_held_edge", zero_e);
        @(negedge clk);
        reset = 1'b1;
        last = zero_e;
        apply("after_reset_idle", aff, b1, 16'h0007, 1'b0, zero_e);
        apply("after_reset_op", aff, b1, 16'h0007, 1'b1,
              '{{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4'd1, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cgra_adder_fu

// File: doc/cgra_adder_fu.md
# cgra_adder_fu

Configurable SIMD adder functional unit for the CGRA tile datapath. Adds two 64-bit operands as four 16-bit lanes, two 32-bit lanes or one 64-bit lane, selected by a per-operation config word. Returns lane results with the routing tag (`dest_info`) and a one-cycle `ack` to the tile's routing fabric.

## Interface
- `width`, 16: lane width in bits.
- `num_inputs`, 4: number of lanes, which is also the number of outputs. Operand count is `2*num_inputs`.

- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inputs`  in  `[width-1:0]` x `2*num_inputs` (unpacked)  operand lanes.
  - Operand A lane i is `inputs[i]`.
  - Operand B lane i is `inputs[i+num_inputs]`.
- `on_off`  in  1  enable. An operation is issued on every rising edge where it is high.
- `config_in`  in  16  operation word.
  - `[1:0]` is `adder_config`.
  - `[5:2]` is `dest_info`.
  - `[15:6]` are reserved and ignored.
- `outputs`  out  `[width-1:0]` x `num_inputs` (unpacked)  result lanes. Lane 0 is least significant.
- `dest_info`  out  4  registered copy of `config_in[5:2]` for the operation whose result is on `outputs`.
- `ack`  out  1  result-valid strobe.

## Operation
- Mode decode from `adder_config`:
  - 0: four independent 16-bit adds. Carry is cut at every lane boundary.
  - 1: two 32-bit adds. Lanes {1,0} and {3,2} are chained; carry is cut between lane 1 and lane 2.
  - 3: one 64-bit add. Carry chains through all lanes.
  - 2: invalid.
- Lane math: `out[i] = A[i] + B[i] + cin[i]`, modulo 2^16.
  - `cin[0]` is 0.
  - `cin[i]` is the carry out of lane i-1 when the chain is enabled for that boundary, otherwise 0.
- Carry out of the most significant lane of each segment is discarded. There is no overflow flag.
- Valid issue (`on_off=1`, `adder_config` 0, 1 or 3):
  - Lane sums are registered into `outputs`.
  - `config_in[5:2]` is registered into `dest_info`.
  - `ack` is registered high.
- Invalid issue (`on_off=1`, `adder_config=2`):
  - `outputs` are registered to 0.
  - `dest_info` is registered to 0.
  - `ack` is registered to 0.
- Idle (`on_off=0`): `outputs` and `dest_info` hold their previous values; `ack` is registered to 0.
- Sustained `on_off=1` recomputes every cycle from the current inputs. There is no internal state beyond the output registers.

## Timing
- Reset (`reset=0`, asynchronous): all `outputs`, `dest_info` and `ack` go to 0 immediately. They stay 0 until the first rising edge after `reset` deasserts.
- Latency is 1 cycle. Inputs sampled at edge N are visible on `outputs`, `dest_info` and `ack` after edge N.
- `ack` is high for exactly the cycles following a valid issue. It is a level, not a toggle; back-to-back issues keep it high.
- No backpressure: the consumer must capture the result in the cycle `ack` is high.
- A mode change between consecutive issues takes effect on the next edge. Old and new modes are never mixed in one result.
- Reset asserted mid-operation discards the in-flight result.

## Structure
- Shared package `cgra_fu_pkg` holds:
  - mode constants: `ADD_4X16=2'd0`, `ADD_2X32=2'd1`, `ADD_1X64=2'd3`;
  - field positions for `config_in`: `ADDER_CFG_LSB=0`, `DEST_LSB=2`, `DEST_W=4`.
- One sub-module, `adder_lane`: a `width`-bit adder with carry-in and carry-out. Instantiate it `num_inputs` times. The carry gating between lanes is derived from the mode.
- Output registers and mode decode live in the top module.

## Test plan
- Reset, then release with idle inputs → all outputs, `dest_info` and `ack` are 0.
- Inputs[0..7] = 0, 10000, 20000, 30000, 40000, 50000, 60000, 4464; `config_in=0x0000`; `on_off=1` → after one edge, outputs = 40000, 60000, 14464, 34464; `ack=1`; `dest_info=0`.
- Same inputs, `config_in=0x0001` → outputs = 40000, 60000, 14464, 34465. Repeat with `config_in=0x0003` → same values.
- A lanes = 0xFFFF x4, B = 1,0,0,0:
  - mode 0 → 0, 0xFFFF, 0xFFFF, 0xFFFF;
  - mode 1 → 0, 0, 0xFFFF, 0xFFFF;
  - mode 3 → 0, 0, 0, 0.
- `config_in=0x0002` → outputs 0, `dest_info=0`, `ack=0`. Then `config_in=0x0034` → mode 0 sums, `dest_info=13`, `ack=1`.
- `on_off` dropped after a valid op → outputs hold, `ack=0` on the next edge. Asserting `reset` mid-stream clears everything without waiting for a clock edge.
